nearest_hit_select: RTL
=======================

Name: nearest_hit_select

Overview:
- Sits directly downstream of the per-object ray/box intersection stage.
- Consumes one (intersects, t) result per object, NUM_OBJECTS results per ray, arriving in object-index order.
- Keeps the nearest valid hit for the current ray and emits one result per ray: hit flag, winning object index and its t.
- Its output drives the shading/colour-select stage.

Parameters:
- NUM_OBJECTS, 8, results per ray (objects tested per pixel); must be >= 2.
- IDX_W, $clog2(NUM_OBJECTS), width of the object index.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- clear_in  input  1  synchronous abort; discards the ray in progress.
- intersects_in  input  1  upstream intersect flag.
- t_in  input  32  upstream IEEE-754 single; entry distance, 0 when no intersection.
- valid_in  input  1  upstream result strobe; one pulse per object.
- hit_out  output  1  any accepted hit for this ray.
- hit_index_out  output  IDX_W  index of the nearest accepted object.
- t_out  output  32  t of the nearest hit; 0x00000000 when hit_out=0.
- valid_out  output  1  one-cycle result strobe, once per ray.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - obj_cnt=0, state=IDLE, accumulator empty (acc_hit=0, acc_idx=0, acc_t=0).
- No backpressure. valid_in may be high on every cycle. The block accepts a result on every cycle.
- Acceptance of a result (valid_in=1):
  - intersects_in=1 and t_in is not NaN (exp=0xFF, mant!=0). NaN is never accepted.
  - t_in sign=0, or t_in==0x80000000. -0.0 is normalised to +0.0 before storing.
  - Negative nonzero t is never accepted (object behind eye).
- Comparison:
  - Candidate replaces the accumulator if acc_hit=0, or cand_t[30:0] < acc_t[30:0] as an unsigned compare. This is valid because both values are non-negative.
  - Equal t keeps the earlier index (strict less-than).
- FSM:
  - IDLE: valid_in → SCAN. The first object initialises the accumulator directly and ignores stale contents. obj_cnt=1.
  - SCAN: each valid_in merges into the accumulator and increments obj_cnt.
  - When valid_in arrives with obj_cnt==NUM_OBJECTS-1 (last object):
    - Merge it.
    - Next cycle: valid_out=1 and outputs register the merged result.
    - obj_cnt→0, state→IDLE.
- Latency: valid_out is 1 cycle after the last object's valid_in.
- Outputs hold their values until the next valid_out; only valid_out is a pulse.
- Back-to-back rays:
  - The last object of ray k and the first object of ray k+1 may arrive on consecutive cycles. No result is lost or mixed.
  - With NUM_OBJECTS consecutive valids, valid_out fires every NUM_OBJECTS cycles.
- clear_in=1:
  - obj_cnt=0, state=IDLE, accumulator emptied.
  - Any valid_in on the same cycle is dropped.
  - Outputs are unchanged and no valid_out is produced.
  - If valid_out is already scheduled (last object on the previous cycle), it still fires.
- Reset mid-ray: everything clears. A partial ray never produces valid_out.
- No-hit ray: valid_out=1, hit_out=0, hit_index_out=0, t_out=0.

Optional Feature:
- HIT_COUNT_EN defined:
  - Adds port hit_count_out, output, width $clog2(NUM_OBJECTS+1).
  - Value = number of accepted hits in the ray. It registers with valid_out and resets to 0.
- HIT_COUNT_EN undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package:
  - FLOAT_ZERO (0x00000000) and FLOAT_NEG_ZERO (0x80000000).
  - Float exp/mant field widths.
  - state enum {IDLE, SCAN}.
- Sub-module float_nonneg_lt: combinational.
  - Inputs a, b. Output a_lt_b on magnitudes, plus is_nan(a).
  - Reused by later shading stages.

Test Plan:
- NUM_OBJECTS=8, all intersects=0:
  - Expect valid_out 1 cycle after the 8th valid_in.
  - Expect hit_out=0, hit_index_out=0, t_out=0x00000000.
- Hits at idx2 t=0x42C80000 (100.0), idx5 t=0x42480000 (50.0), idx6 t=0x41C80000 (25.0) → hit_out=1, idx=6, t_out=0x41C80000.
- idx1 t=-5.0 (0xC0A00000) intersecting, idx3 t=50.0 → idx=3. NaN 0x7FC00000 at idx0 is never selected.
- Tie: idx1 and idx4 both t=50.0 → idx=1.
- Two rays with 16 consecutive valid_in cycles, ray1 nearest idx7 and ray2 nearest idx0:
  - Expect two valid_out pulses 8 cycles apart.
  - Results idx7 then idx0, with no carry-over.
- clear_in asserted after 4 objects, then 8 fresh objects:
  - Exactly one valid_out, reflecting only the fresh objects.
  - Assert rst_n_in mid-ray: outputs 0 immediately and no valid_out.

Source files
------------

// File: rtl/nearest_hit_select_pkg.sv
// Shared definitions for the nearest-hit selection block and its float helper.
// Contents: IEEE-754 single-precision field widths and special encodings, and
// the ray-scan FSM state type.
package nearest_hit_select_pkg;

  localparam int unsigned FLOAT_W      = 32;
  localparam int unsigned FLOAT_EXP_W  = 8;
  localparam int unsigned FLOAT_MANT_W = 23;

  localparam logic [FLOAT_W-1:0] FLOAT_ZERO     = 32'h0000_0000;
  localparam logic [FLOAT_W-1:0] FLOAT_NEG_ZERO = 32'h8000_0000;

  typedef enum logic {
    StIdle,
    StScan
  } state_e;

endpackage

// File: rtl/nearest_hit_select_float_nonneg_lt.sv
// float_nonneg_lt: combinational magnitude comparator for IEEE-754 singles that
// are known to be non-negative (or +/-0), plus a NaN detector on operand a.
// Ports:
//   a, b     : 32-bit IEEE-754 single operands
//   a_lt_b   : |a| < |b|, valid as a float compare when both are non-negative
//   a_is_nan : a has an all-ones exponent and a nonzero mantissa
module nearest_hit_select_float_nonneg_lt
  import nearest_hit_select_pkg::*;
(
  input  logic [FLOAT_W-1:0] a,
  input  logic [FLOAT_W-1:0] b,
  output logic               a_lt_b,
  output logic               a_is_nan
);

  // Sign bits play no part in a magnitude compare.
  logic unused_sign;
  assign unused_sign = a[FLOAT_W-1] ^ b[FLOAT_W-1];

  // For non-negative IEEE-754 values the bit pattern orders like an integer.
  assign a_lt_b = a[FLOAT_W-2:0] < b[FLOAT_W-2:0];

  assign a_is_nan = (a[FLOAT_W-2 -: FLOAT_EXP_W] == '1) && (a[FLOAT_MANT_W-1:0] != '0);

endmodule

// File: rtl/nearest_hit_select.sv
// nearest_hit_select: reduces NUM_OBJECTS per-object (intersects, t) results of
// one ray to the nearest accepted hit and emits one result per ray.
// Ports:
//   clk_in, rst_n_in   : clock, asynchronous active-low reset
//   clear_in           : synchronous abort of the ray in progress
//   intersects_in      : upstream intersect flag
//   t_in               : upstream IEEE-754 single entry distance
//   valid_in           : one strobe per object, in object-index order
//   hit_out            : any accepted hit in the ray
//   hit_index_out      : index of the nearest accepted object
//   t_out              : t of the nearest hit, +0.0 when no hit
//   valid_out          : one-cycle strobe per ray
//   hit_count_out      : accepted hits in the ray (only when HIT_COUNT_EN is defined)
// Optional feature macro: HIT_COUNT_EN.
module nearest_hit_select
  import nearest_hit_select_pkg::*;
#(
  parameter int unsigned NUM_OBJECTS = 8,
  parameter int unsigned IDX_W       = $clog2(NUM_OBJECTS)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               clear_in,
  input  logic               intersects_in,
  input  logic [FLOAT_W-1:0] t_in,
  input  logic               valid_in,
  output logic               hit_out,
  output logic [IDX_W-1:0]   hit_index_out,
  output logic [FLOAT_W-1:0] t_out,
  output logic               valid_out
`ifdef HIT_COUNT_EN
  ,
  output logic [$clog2(NUM_OBJECTS+1)-1:0] hit_count_out
`endif
);

  localparam int unsigned HC_W = $clog2(NUM_OBJECTS + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   obj_cnt_q, obj_cnt_d;
  logic               acc_hit_q, acc_hit_d;
  logic [IDX_W-1:0]   acc_idx_q, acc_idx_d;
  logic [FLOAT_W-1:0] acc_t_q, acc_t_d;
  logic [HC_W-1:0]    acc_cnt_q, acc_cnt_d;

  logic [FLOAT_W-1:0] cand_t;
  logic               cand_lt, cand_nan;
  logic               take, accept, last;
  logic               base_hit, merge_hit;
  logic [IDX_W-1:0]   base_idx, merge_idx;
  logic [FLOAT_W-1:0] base_t, merge_t;
  logic [HC_W-1:0]    base_cnt, merge_cnt;

  nearest_hit_select_float_nonneg_lt u_lt (
    .a        (cand_t),
    .b        (acc_t_q),
    .a_lt_b   (cand_lt),
    .a_is_nan (cand_nan)
  );

  always_comb begin
    cand_t = (t_in == FLOAT_NEG_ZERO) ? FLOAT_ZERO : t_in;
    take   = valid_in && !clear_in;
    accept = take && intersects_in && !cand_nan &&
             (!t_in[FLOAT_W-1] || (t_in == FLOAT_NEG_ZERO));
    last   = take && (obj_cnt_q == IDX_W'(NUM_OBJECTS - 1));

    // The first object of a ray merges into an empty accumulator, so stale
    // contents from an earlier ray can never win.
    base_hit = (state_q == StScan) ? acc_hit_q : 1'b0;
    base_idx = (state_q == StScan) ? acc_idx_q : '0;
    base_t   = (state_q == StScan) ? acc_t_q   : FLOAT_ZERO;
    base_cnt = (state_q == StScan) ? acc_cnt_q : '0;

    merge_hit = base_hit;
    merge_idx = base_idx;
    merge_t   = base_t;
    merge_cnt = base_cnt + HC_W'(accept);
    // Strict less-than: on equal t the earlier index is kept.
    if (accept && (!base_hit || cand_lt)) begin
      merge_hit = 1'b1;
      merge_idx = obj_cnt_q;
      merge_t   = cand_t;
    end

    state_d   = state_q;
    obj_cnt_d = obj_cnt_q;
    acc_hit_d = acc_hit_q;
    acc_idx_d = acc_idx_q;
    acc_t_d   = acc_t_q;
    acc_cnt_d = acc_cnt_q;
    if (clear_in || last) begin
      state_d   = StIdle;
      obj_cnt_d = '0;
      acc_hit_d = 1'b0;
      acc_idx_d = '0;
      acc_t_d   = FLOAT_ZERO;
      acc_cnt_d = '0;
    end else if (take) begin
      state_d   = StScan;
      obj_cnt_d = obj_cnt_q + IDX_W'(1);
      acc_hit_d = merge_hit;
      acc_idx_d = merge_idx;
      acc_t_d   = merge_t;
      acc_cnt_d = merge_cnt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      obj_cnt_q <= '0;
      acc_hit_q <= 1'b0;
      acc_idx_q <= '0;
      acc_t_q   <= FLOAT_ZERO;
      acc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      obj_cnt_q <= obj_cnt_d;
      acc_hit_q <= acc_hit_d;
      acc_idx_q <= acc_idx_d;
      acc_t_q   <= acc_t_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  // Result registers load the merged value together with the last object, so
  // a clear on the following cycle cannot cancel the scheduled strobe.
  logic [HC_W-1:0] hit_count_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out     <= 1'b0;
      hit_out       <= 1'b0;
      hit_index_out <= '0;
      t_out         <= FLOAT_ZERO;
      hit_count_q   <= '0;
    end else begin
      valid_out <= last;
      if (last) begin
        hit_out       <= merge_hit;
        hit_index_out <= merge_idx;
        t_out         <= merge_t;
        hit_count_q   <= merge_cnt;
      end
    end
  end

`ifdef HIT_COUNT_EN
  assign hit_count_out = hit_count_q;
`else
  logic unused_hit_count;
  assign unused_hit_count = ^hit_count_q;
`endif

endmodule
